// File: rtl/noise_voice_sched.sv
// Time-multiplexed Galois-LFSR noise generator: one shared datapath sweeps NUM_VOICES voices per sample_tick.
// Optional sweep mix output is built when NOISE_SCHED_MIX_EN is defined; otherwise mix_valid/mix_sample read 0.
module noise_voice_sched #(
  parameter int          NUM_VOICES = 4,
  parameter int          PERIOD_W   = 17,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS  = 16'hD008,
  localparam int         VW         = $clog2(NUM_VOICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [VW-1:0]        cfg_voice,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic                 cfg_en,
  output logic                 out_valid,
  output logic [VW-1:0]        out_voice,
  output logic signed [15:0]   out_sample,
  output logic                 mix_valid,
  output logic signed [15+VW:0] mix_sample,
  output logic                 overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [VW-1:0]       idx;
  logic [15:0]         lfsr    [NUM_VOICES];
  logic [PERIOD_W-1:0] counter [NUM_VOICES];
  logic [PERIOD_W-1:0] period  [NUM_VOICES];
  logic                en      [NUM_VOICES];

  logic                cfg_accept;
  logic signed [15:0]  svc_sample;
  logic [15:0]         svc_lfsr_next;

  assign cfg_ready  = (state == S_IDLE);
  assign cfg_accept = cfg_valid && cfg_ready && (int'(cfg_voice) < NUM_VOICES);

  // Sample is taken from the LFSR value before this service's step.
  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    svc_sample    = 16'sh0000;
    svc_lfsr_next = {1'b0, lfsr[idx][15:1]} ^ (lfsr[idx][0] ? LFSR_TAPS : 16'h0000);
    if (en[idx]) begin
      svc_sample = lfsr[idx][0] ? 16'sh7FFF : 16'sh8000;
    end
  end

  // NOTE: per-voice state is a small register file (not RAM), so it is reset explicitly in a loop.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_sample <= '0;
      overrun    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        lfsr[v]    <= LFSR_SEED;
        counter[v] <= '0;
        period[v]  <= '0;
        en[v]      <= 1'b0;
      end
    end else begin
      overrun   <= sample_tick && (state != S_IDLE);
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_accept) begin
            period[cfg_voice]  <= cfg_period;
            en[cfg_voice]      <= cfg_en;
            counter[cfg_voice] <= '0;
          end
          if (sample_tick) begin
            state <= S_SCAN;
            idx   <= '0;
          end
        end
        S_SCAN: begin
          out_valid  <= 1'b1;
          out_voice  <= idx;
          out_sample <= svc_sample;
          if (en[idx]) begin
            if (counter[idx] >= period[idx]) begin
              lfsr[idx]    <= svc_lfsr_next;
              counter[idx] <= '0;
            end else begin
              counter[idx] <= counter[idx] + 1'b1;
            end
          end
          if (idx == VW'(NUM_VOICES - 1)) state <= S_DONE;
          else                            idx   <= idx + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NOISE_SCHED_MIX_EN
  logic signed [15+VW:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      mix_valid  <= 1'b0;
      mix_sample <= '0;
    end else begin
      mix_valid <= 1'b0;
      if (state == S_IDLE && sample_tick) begin
        acc <= '0;
      end else if (state == S_SCAN) begin
        acc <= acc + {{VW{svc_sample[15]}}, svc_sample};
      end else if (state == S_DONE) begin
        mix_valid  <= 1'b1;
        mix_sample <= acc;
      end
    end
  end
`else
  assign mix_valid  = 1'b0;
  assign mix_sample = '0;
`endif

endmodule

// File: tb/tb_noise_voice_sched.sv
// Self-checking bench for noise_voice_sched: directed tables, corner sequences and a randomized
// phase compared against a per-voice behavioural noise model.
module tb_noise_voice_sched;

  localparam int NV = 4;
`ifdef NOISE_SCHED_MIX_EN
  localparam bit MIX_ON = 1'b1;
`else
  localparam bit MIX_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_voice;
  logic [16:0]        cfg_period;
  logic               cfg_en;
  logic               out_valid;
  logic [1:0]         out_voice;
  logic signed [15:0] out_sample;
  logic               mix_valid;
  logic signed [17:0] mix_sample;
  logic               overrun;

  noise_voice_sched dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
    .cfg_period(cfg_period), .cfg_en(cfg_en),
    .out_valid(out_valid), .out_voice(out_voice), .out_sample(out_sample),
    .mix_valid(mix_valid), .mix_sample(mix_sample), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: each voice is a noise source that advances its LFSR every period+1 services.
  logic [15:0] m_lfsr [NV];
  int          m_cnt  [NV];
  int          m_per  [NV];
  bit          m_en   [NV];
  int          m_mix;
  int          got    [NV];

  typedef struct { int s0; int s1; } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_lfsr[v] = 16'hACE1; m_cnt[v] = 0; m_per[v] = 0; m_en[v] = 1'b0;
    end
    m_mix = 0;
  endtask

  task automatic model_cfg(input int v, input int p, input bit e);
    m_per[v] = p; m_en[v] = e; m_cnt[v] = 0;
  endtask

  task automatic model_service(input int v, output int s);
    logic [15:0] l;
    s = 0;
    if (m_en[v]) begin
      l = m_lfsr[v];
      s = l[0] ? 32767 : -32768;
      if (m_cnt[v] >= m_per[v]) begin
        m_lfsr[v] = (l >> 1) ^ (l[0] ? 16'hD008 : 16'h0000);
        m_cnt[v]  = 0;
      end else begin
        m_cnt[v]++;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic idle_cfg(input int v, input int p, input bit e);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_voice = 2'(v); cfg_period = 17'(p); cfg_en = e;
    @(negedge clk);
    cfg_valid = 1'b0;
    model_cfg(v, p, e);
  endtask

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic sweep(input bit extra_tick, input bit cfg_do, input int cv, input int cp,
                       input bit ce, input bit junk_cfg);
    int acc, s;
    if (cfg_do) begin
      cfg_valid = 1'b1; cfg_voice = 2'(cv); cfg_period = 17'(cp); cfg_en = ce;
      model_cfg(cv, cp, ce);
    end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    cfg_valid   = junk_cfg;
    if (junk_cfg) begin
      cfg_voice = 2'($urandom_range(0, 3)); cfg_period = 17'($urandom); cfg_en = 1'($urandom);
    end
    acc = 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      model_service(i, s);
      acc += s;
      check("out_valid", out_valid, 1);
      check("out_voice", out_voice, i);
      check("out_sample", out_sample, s);
      check("cfg_ready_busy", cfg_ready, 0);
      check("overrun", overrun, (extra_tick && i == 2) ? 1 : 0);
      check("mix_valid_scan", mix_valid, 0);
      got[i] = out_sample;
      sample_tick = extra_tick && (i == 1);
      if (i == 2) cfg_valid = 1'b0;
    end
    sample_tick = 1'b0;
    @(negedge clk);
    if (MIX_ON) m_mix = acc;
    check("out_valid_done", out_valid, 0);
    check("mix_valid", mix_valid, MIX_ON ? 1 : 0);
    check("mix_sample", mix_sample, m_mix);
    @(negedge clk);
    check("cfg_ready_back", cfg_ready, 1);
    check("mix_valid_low", mix_valid, 0);
    check("out_valid_idle", out_valid, 0);
  endtask

  initial begin
    tbl[0] = '{ 32767,  32767};
    tbl[1] = '{-32768,  32767};
    tbl[2] = '{-32768,  32767};
    tbl[3] = '{-32768, -32768};
    tbl[4] = '{ 32767, -32768};
    tbl[5] = '{ 32767, -32768};
    tbl[6] = '{ 32767, -32768};

    rst = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0;
    cfg_voice = '0; cfg_period = '0; cfg_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_out_voice", out_voice, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_mix_sample", mix_sample, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // All voices disabled: four zero samples and a zero mix.
    sweep(0, 0, 0, 0, 0, 0);

    // v0 steps every sweep, v1 every third sweep.
    reset_dut();
    idle_cfg(0, 0, 1);
    idle_cfg(1, 2, 1);
    for (int k = 0; k < 7; k++) begin
      sweep(0, 0, 0, 0, 0, 0);
      check("tbl_v0", got[0], tbl[k].s0);
      check("tbl_v1", got[1], tbl[k].s1);
      check("tbl_v2", got[2], 0);
    end

    // Equal seeds, all enabled: mix is four times one sample.
    reset_dut();
    for (int v = 0; v < NV; v++) idle_cfg(v, 0, 1);
    sweep(0, 0, 0, 0, 0, 0);
    check("mix_all_pos", mix_sample, MIX_ON ? 131068 : 0);
    sweep(0, 0, 0, 0, 0, 0);
    check("mix_all_neg", mix_sample, MIX_ON ? -131072 : 0);
    repeat (3) @(negedge clk);
    check("mix_hold", mix_sample, MIX_ON ? -131072 : 0);

    // Tick during SCAN is dropped; simultaneous config and tick uses the new config.
    sweep(1, 0, 0, 0, 0, 0);
    sweep(0, 1, 2, 0, 0, 0);
    check("cfg_with_tick_v2", got[2], 0);

    // Reset in the middle of a sweep.
    reset_dut();
    idle_cfg(0, 0, 1);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_voice2", out_voice, 2);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sample", out_sample, 0);
    check("mid_rst_voice", out_voice, 0);
    check("mid_rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_no_mix", mix_valid, 0);
      check("mid_no_out", out_valid, 0);
    end
    idle_cfg(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      sweep(0, 0, 0, 0, 0, 0);
      check("post_rst_v0", got[0], tbl[k].s0);
    end

    // Randomized configuration and tick traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1)
          idle_cfg($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 3) != 0));
        else
          @(negedge clk);
        check("rand_mix_hold", mix_sample, m_mix);
      end
      sweep(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
            1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
